// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

    // Loader frame states, in the order a well-formed frame visits them.
    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    // Start-of-frame marker byte.
    localparam logic [7:0] SOF_BYTE = 8'hA5;

    // Width of the frame length field (word count).
    localparam int LEN_W = 16;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs incoming bytes big-endian into a 32-bit word and keeps the running
// XOR checksum of every data byte seen since the last clear.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [7:0]  checksum,
    output logic        last_byte
);

    logic [1:0] byte_idx;

    // Shift the new byte in at the bottom so the first byte ends up in [31:24].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            checksum <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            checksum <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            checksum <= checksum ^ byte_in;
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign last_byte = (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory. Holds the CPU until a
// complete, checksum-verified image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(1),
    parameter int               ADDR_STEP = 4,
    parameter int               MAX_WORDS = 256,
    parameter logic [7:0]       SOF       = SOF_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

    state_t           state;
    state_t           state_next;
    logic             ready_q;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_next;
    logic             accept;
    logic             frame_start;
    logic [7:0]       checksum;
    logic             last_byte;

    assign accept      = rx_valid & rx_ready;
    assign frame_start = accept && (rx_data == SOF) &&
                         ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign len_next    = {len[15:8], rx_data};

    byte_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (frame_start),
        .shift_en  (accept && (state == DATA)),
        .byte_in   (rx_data),
        .word      (imem_wdata),
        .checksum  (checksum),
        .last_byte (last_byte)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame length, word counter and the ready enable that comes up one clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            len          <= '0;
            words_loaded <= '0;
        end else begin
            ready_q <= 1'b1;
            if (frame_start) begin
                len          <= '0;
                words_loaded <= '0;
            end else if (accept && (state == LEN_HI)) begin
                len[15:8] <= rx_data;
            end else if (accept && (state == LEN_LO)) begin
                len[7:0] <= rx_data;
            end else if (state == WRITE) begin
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end

    // Next-state decode and the status/handshake outputs derived from the state.
    always_comb begin
        state_next = state;
        imem_we    = 1'b0;
        rx_ready   = ready_q;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_err   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if ((len_next == '0) || (len_next > MAX_LEN)) state_next = ERROR;
                    else                                         state_next = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte) state_next = WRITE;
            end
            WRITE: begin
                imem_we  = 1'b1;
                rx_ready = 1'b0;
                if ((words_loaded + 16'd1) < len) state_next = DATA;
                else                              state_next = CSUM;
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == checksum) state_next = DONE;
                    else                     state_next = ERROR;
                end
            end
            DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
                if (frame_start) state_next = LEN_HI;
            end
            ERROR: begin
                load_err = 1'b1;
                if (frame_start) state_next = LEN_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_addr = BASE_ADDR + STEP * ADDR_W'(words_loaded);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream writer for the instruction memory that the fetch stage reads. It receives a framed program image over a valid/ready byte channel and packs bytes big-endian into 32-bit instructions. It writes each word into instruction memory at sequential byte addresses and holds the CPU off until the image is complete and checksum-verified. It replaces hierarchical pokes into instruction memory as the way programs are loaded into the pipeline.

Parameters:
ADDR_W, 32, instruction memory address width
BASE_ADDR, 1, byte address of the first loaded word (the PC reset value)
ADDR_STEP, 4, address increment per word
MAX_WORDS, 256, maximum accepted word count
SOF, 8'hA5, start-of-frame byte

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction memory write strobe, one cycle per word
imem_addr  out  ADDR_W  write byte address
imem_wdata  out  32  write data
cpu_hold  out  1  high while the pipeline must stay stalled/flushed
load_done  out  1  image loaded and checksum OK
load_err  out  1  frame error (bad length or checksum)
words_loaded  out  16  count of words written in the current frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; rx_ready=0 while in reset, 1 on the first clk after release. imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0, checksum=0.
- Byte accepted iff rx_valid & rx_ready at a rising clk edge.
- Frame format: SOF, LEN_HI, LEN_LO, then 4*LEN data bytes, then CSUM. CSUM = XOR of all data bytes only.
- FSM:
  - IDLE: a non-SOF byte is discarded. SOF -> LEN_HI, with cpu_hold=1, load_done=0, load_err=0, words_loaded=0, checksum=0.
  - LEN_HI: latch len[15:8] -> LEN_LO.
  - LEN_LO: latch len[7:0]. If len==0 or len>MAX_WORDS -> ERROR, else -> DATA with byte index 0.
  - DATA: shift the byte into the word, first byte to [31:24]; checksum ^= byte. The 4th byte -> WRITE.
  - WRITE (1 cycle): imem_we=1, imem_wdata=word, imem_addr=BASE_ADDR+ADDR_STEP*words_loaded, rx_ready=0. words_loaded increments at the end of the cycle. -> DATA if words_loaded+1<len, else -> CSUM.
  - CSUM: byte==checksum -> DONE, else -> ERROR.
  - DONE: cpu_hold=0, load_done=1. An SOF byte restarts the frame (same actions as IDLE on SOF); other bytes are discarded.
  - ERROR: cpu_hold=1, load_err=1. Already-written words are not rolled back. SOF restarts the frame; other bytes are discarded.
- imem_we is high only in WRITE; there are never two consecutive write cycles.
- Latency: WRITE occurs the cycle after the 4th data byte is accepted. load_done rises the cycle after the CSUM byte is accepted.
- imem_addr arithmetic is modulo 2^ADDR_W; wrap is not flagged.
- Reset mid-frame: abort, return to reset values. Partial writes remain in memory.
- rx_valid may drop between bytes at any point; the FSM simply waits, with no timeout.

Decomposition:
- Shared package: state enum (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERROR), SOF constant, frame-length width constant.
- Optional sub-module byte_word_packer: 4-byte shift register, byte index counter, running XOR. The FSM and address counter stay in imem_loader.

Test Plan:
- Nominal load: A5 00 03 | 8C 22 00 02 | 00 22 18 20 | 00 62 20 22 | D6 -> writes (1,8C220002), (5,00221820), (9,00622022); load_done=1, cpu_hold=0, words_loaded=3.
- Bad checksum: same frame with CSUM=D7 -> three writes occur, load_err=1, cpu_hold=1, load_done=0.
- Length errors: A5 00 00 -> ERROR with no writes. A5 01 01 (257 > MAX_WORDS) -> ERROR.
- Stall and junk: leading bytes 00 FF before SOF are ignored; rx_valid toggles every other cycle in DATA -> identical writes to the nominal case. rx_ready=0 exactly during each WRITE cycle.
- Reset mid-frame: rst_n=0 after the 6th data byte -> outputs return to reset values asynchronously. A following nominal frame completes correctly with addresses restarting at 1.
- Reload after DONE: a second frame A5 00 01 | 00 00 00 00 | 00 -> cpu_hold rises at SOF, one write to address 1 with data 0, then DONE.
